pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 23 ++
 rtl/pipe_ctrl_fwd.sv | 23 ++
 rtl/pipe_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller:
// FSM states, forwarding selects, branch types, timeout.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ERR      = 2'b10
    } state_e;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] BT_EQ = 2'b00;
    localparam logic [1:0] BT_NE = 2'b01;
    localparam logic [1:0] BT_LT = 2'b10;
    localparam logic [1:0] BT_GE = 2'b11;

    localparam logic [7:0]  MEM_TIMEOUT = 8'd255;
    localparam logic [15:0] CNT_MAX     = 16'hFFFF;

endpackage

// File: rtl/pipe_ctrl_fwd.sv
// Operand forwarding select for one ALU source.
// The EX/MEM result is newer, so it wins over MEM/WB.
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic [4:0] exmem_rd_i,
    input  logic       exmem_we_i,
    input  logic [4:0] memwb_rd_i,
    input  logic       memwb_we_i,
    output logic [1:0] sel_o
);

    // Pick the youngest in-flight writer of rs; x0 never forwards
    always_comb begin
        sel_o = FWD_REG;
        if (exmem_we_i && exmem_rd_i != 5'd0 && exmem_rd_i == rs_i)
            sel_o = FWD_MEM;
        else if (memwb_we_i && memwb_rd_i != 5'd0 && memwb_rd_i == rs_i)
            sel_o = FWD_WB;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stalls, redirects, forwarding,
// data-memory wait tracking with timeout, event counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  idex_rd,
    input  logic        idex_memRead,
    input  logic [4:0]  exmem_rd,
    input  logic        exmem_regWrite,
    input  logic [4:0]  memwb_rd,
    input  logic        memwb_regWrite,
    input  logic        exmem_branch,
    input  logic        exmem_jump,
    input  logic        exmem_zero,
    input  logic        exmem_lt_zero,
    input  logic        exmem_memRead,
    input  logic        exmem_memWrite,
    input  logic [1:0]  exmem_bType,
    input  logic        dmem_ack,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        pc_sel,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic        mem_err
);

    state_e      state_q;
    logic [7:0]  wait_q;
    logic [7:0]  wait_inc;
    logic        mem_err_q;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic        cond, taken, mem_stall, load_use, in_err;
    logic        stall_inc, flush_inc;

    assign in_err   = (state_q == ST_ERR);
    assign wait_inc = wait_q + 8'd1;

    // Branch condition selected by branch type
    always_comb begin
        cond = 1'b0;
        unique case (exmem_bType)
            BT_EQ: cond = exmem_zero;
            BT_NE: cond = !exmem_zero;
            BT_LT: cond = exmem_lt_zero;
            BT_GE: cond = !exmem_lt_zero;
        endcase
    end

    assign taken     = exmem_jump | (exmem_branch & cond);
    assign mem_stall = !in_err & (exmem_memRead | exmem_memWrite)
                     & !dmem_ack;
    assign load_use  = idex_memRead & (idex_rd != 5'd0)
                     & ((idex_rd == id_rs1) | (idex_rd == id_rs2));

    // Priority resolution: ERR, memory stall, redirect, load-use
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        pc_sel      = 1'b0;
        if (in_err || mem_stall) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (taken) begin
            pc_sel      = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    fwd_unit u_fwd_a (
        .rs_i       (id_rs1),
        .exmem_rd_i (exmem_rd),
        .exmem_we_i (exmem_regWrite),
        .memwb_rd_i (memwb_rd),
        .memwb_we_i (memwb_regWrite),
        .sel_o      (fwd_a)
    );

    fwd_unit u_fwd_b (
        .rs_i       (id_rs2),
        .exmem_rd_i (exmem_rd),
        .exmem_we_i (exmem_regWrite),
        .memwb_rd_i (memwb_rd),
        .memwb_we_i (memwb_regWrite),
        .sel_o      (fwd_b)
    );

    assign stall_inc = !in_err & (mem_stall | (load_use & !taken));
    assign flush_inc = !in_err & !mem_stall & taken;

    // Saturating event counters, next-state
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc && stall_cnt_q != CNT_MAX)
            stall_cnt_d = stall_cnt_q + 16'd1;
        if (flush_inc && flush_cnt_q != CNT_MAX)
            flush_cnt_d = flush_cnt_q + 16'd1;
    end

    // Event counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Memory-wait FSM; leaving MEM_WAIT needs the stall to clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            wait_q    <= 8'd0;
            mem_err_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (mem_stall) begin
                        state_q <= ST_MEM_WAIT;
                        wait_q  <= 8'd0;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!mem_stall) begin
                        state_q <= ST_RUN;
                    end else if (wait_inc == MEM_TIMEOUT) begin
                        state_q   <= ST_ERR;
                        mem_err_q <= 1'b1;
                    end else begin
                        wait_q <= wait_inc;
                    end
                end
                ST_ERR: mem_err_q <= 1'b1;
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign mem_err   = mem_err_q;

endmodule
